// File: rtl/wokwi_395567106413190145.sv
// Multi-mode 8-bit sequence generator for a TinyTapeout microtile.
// One state register drives uo_out directly. When enabled, it steps as an
// up-counter, down-counter, Fibonacci LFSR or 5-bit shift-loader, chosen by
// the 2-bit mode field of ui_in.
module wokwi_395567106413190145 #(
  parameter logic [7:0] RESET_VALUE = 8'h00,
  parameter logic [7:0] LFSR_SEED   = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {
    MODE_UP    = 2'b00,
    MODE_DOWN  = 2'b01,
    MODE_LFSR  = 2'b10,
    MODE_SHIFT = 2'b11
  } mode_e;

  logic       en;
  mode_e      mode;
  logic [4:0] din;
  logic [7:0] q;
  logic [7:0] q_next;
  logic       fb;

  assign en   = ui_in[0];
  assign mode = mode_e'(ui_in[2:1]);
  assign din  = ui_in[7:3];

  // Feedback taps for x^8+x^6+x^5+x^4+1.
  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  // Next-state selection. The zero state would lock the LFSR, so it is
  // replaced by the seed.
  always_comb begin
    // NOTE: a default assignment first means every path drives q_next, so no latch is inferred.
    q_next = q;
    if (en) begin
      unique case (mode)
        MODE_UP:    q_next = q + 8'd1;
        MODE_DOWN:  q_next = q - 8'd1;
        MODE_LFSR:  q_next = (q == 8'h00) ? LFSR_SEED : {q[6:0], fb};
        MODE_SHIFT: q_next = {q[2:0], din};
        default:    q_next = q;
      endcase
    end
  end

  // State register: asynchronous clear, then one update per rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment keeps every register updating from pre-edge values.
    if (!rst_n) q <= RESET_VALUE;
    else        q <= q_next;
  end

  assign uo_out = q;

endmodule

// File: tb/tb_wokwi_395567106413190145.sv
// Self-checking bench for the multi-mode sequence generator.
// Directed vector table, hand-written corner sequences and a randomised
// run against a behavioural model.
module tb_wokwi_395567106413190145;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  int checks = 0;
  int errors = 0;

  wokwi_395567106413190145 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ui;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Behavioural model: arithmetic modulo 256, LFSR feedback as tap-mask parity.
  function automatic logic [7:0] model(input logic [7:0] q, input logic [7:0] ui);
    int v;
    logic [7:0] r;
    r = q;
    if (ui[0]) begin
      case (ui[2:1])
        2'd0: begin v = (int'(q) + 1) % 256;   r = 8'(v); end
        2'd1: begin v = (int'(q) + 255) % 256; r = 8'(v); end
        2'd2: r = (q == 8'h00) ? 8'h01 : 8'((int'(q) * 2) % 256) | {7'd0, ^(q & 8'hB8)};
        default: begin v = ((int'(q) * 32) % 256) + int'(ui[7:3]); r = 8'(v); end
      endcase
    end
    return r;
  endfunction

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic [7:0] ui);
    @(negedge clk);
    ui_in = ui;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between edges, released on a falling edge.
  task automatic pulse_reset();
    #2;
    ui_in = 8'h00;
    rst_n = 1'b0;
    #1;
    check("async_reset", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] q_m;
    logic [7:0] r;
    logic [7:0] held;
    int zeros;
    int first_ret;

    vecs[0]  = '{8'h01, 8'h01};
    vecs[1]  = '{8'h01, 8'h02};
    vecs[2]  = '{8'h01, 8'h03};
    vecs[3]  = '{8'h00, 8'h03};
    vecs[4]  = '{8'hFE, 8'h03};
    vecs[5]  = '{8'h03, 8'h02};
    vecs[6]  = '{8'h03, 8'h01};
    vecs[7]  = '{8'h03, 8'h00};
    vecs[8]  = '{8'h03, 8'hFF};
    vecs[9]  = '{8'h03, 8'hFE};
    vecs[10] = '{8'hAF, 8'hD5};
    vecs[11] = '{8'hAF, 8'hB5};
    vecs[12] = '{8'h05, 8'h6B};

    rst_n = 1'b0;
    ui_in = 8'h01;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", uo_out, 8'h00);
    end
    @(negedge clk);
    ui_in = 8'h00;
    rst_n = 1'b1;

    // Directed table from the reset state.
    foreach (vecs[i]) begin
      step(vecs[i].ui);
      check($sformatf("vec%0d", i), uo_out, vecs[i].exp);
    end

    // Reset asserted mid-count.
    step(8'h01);
    pulse_reset();

    // Down-count from 00.
    step(8'h03); check("down_wrap", uo_out, 8'hFF);
    step(8'h03); check("down_fe", uo_out, 8'hFE);

    // Shift-load from 00.
    pulse_reset();
    step(8'hAF); check("shift_15", uo_out, 8'h15);
    step(8'hAF); check("shift_b5", uo_out, 8'hB5);

    // Reach FF by shift-load, then up-count wraps to 00.
    pulse_reset();
    step(8'hFF); check("shift_1f", uo_out, 8'h1F);
    step(8'hFF); check("shift_ff", uo_out, 8'hFF);
    step(8'h01); check("up_wrap", uo_out, 8'h00);

    // Hold for 10 edges with en=0, mixed mode/din.
    step(8'h01); step(8'h01);
    held = 8'h02;
    for (int i = 0; i < 10; i++) begin
      step((i % 2 == 0) ? 8'h00 : 8'hFE);
      check("hold", uo_out, held);
    end

    // LFSR from 00: seed, then known prefix, then full period.
    pulse_reset();
    step(8'h05); check("lfsr_seed", uo_out, 8'h01);
    step(8'h05); check("lfsr_02", uo_out, 8'h02);
    step(8'h05); check("lfsr_04", uo_out, 8'h04);
    step(8'h05); check("lfsr_08", uo_out, 8'h08);
    step(8'h05); check("lfsr_11", uo_out, 8'h11);
    zeros = 0;
    first_ret = 0;
    for (int i = 5; i <= 255; i++) begin
      step(8'h05);
      if (uo_out == 8'h00) zeros++;
      if (uo_out == 8'h01 && first_ret == 0) first_ret = i;
    end
    check("lfsr_period_end", uo_out, 8'h01);
    check("lfsr_no_zero", 8'(zeros), 8'h00);
    check("lfsr_first_return", 8'(first_ret), 8'd255);

    // Randomised run against the model.
    pulse_reset();
    q_m = 8'h00;
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom);
      step(r);
      q_m = model(q_m, r);
      check($sformatf("rand%0d_ui%02h", i, r), uo_out, q_m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
